// File: rtl/udp_tx.sv
// UDP transmit stage: prepends one 64-bit UDP header (checksum 0) to an AXIS payload, cut-through.
// Optional macro UDP_DYNAMIC_PORT_EN adds runtime-loadable source/destination port inputs.
module udp_tx #(
  parameter logic [15:0] P_SRC_PORT    = 16'd8080,
  parameter logic [15:0] P_DST_PORT    = 16'd8080,
  parameter logic [15:0] P_ID_INIT     = 16'd0,
  parameter logic [15:0] P_MAX_PAYLOAD = 16'd1472
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] s_axis_app_data,
  input  logic [15:0] s_axis_app_user,
  input  logic [7:0]  s_axis_app_keep,
  input  logic        s_axis_app_last,
  input  logic        s_axis_app_valid,
  output logic        s_axis_app_ready,
  output logic [63:0] m_axis_ip_data,
  output logic [55:0] m_axis_ip_user,
  output logic [7:0]  m_axis_ip_keep,
  output logic        m_axis_ip_last,
  output logic        m_axis_ip_valid,
  input  logic        m_axis_ip_ready,
`ifdef UDP_DYNAMIC_PORT_EN
  input  logic [15:0] i_dynamic_src_port,
  input  logic        i_dynamic_src_valid,
  input  logic [15:0] i_dynamic_dst_port,
  input  logic        i_dynamic_dst_valid,
`endif
  output logic        o_len_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] ip_id_q, ip_id_d;
  logic [63:0] m_data_q, m_data_d;
  logic [55:0] m_user_q, m_user_d;
  logic [7:0]  m_keep_q, m_keep_d;
  logic        m_last_q, m_last_d;
  logic        m_valid_q, m_valid_d;
  logic        len_err_q, len_err_d;

  logic [15:0] src_port, dst_port;
  logic [15:0] udp_len;
  logic        out_free;
  logic        len_bad;
  logic        pay_acc;
  logic        drop_acc;

`ifdef UDP_DYNAMIC_PORT_EN
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;

  // A pulse coinciding with the header load only lands in the register, so the header keeps the old port.
  always_comb begin
    src_port_d = i_dynamic_src_valid ? i_dynamic_src_port : src_port_q;
    dst_port_d = i_dynamic_dst_valid ? i_dynamic_dst_port : dst_port_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_port_q <= P_SRC_PORT;
      dst_port_q <= P_DST_PORT;
    end else begin
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
    end
  end

  assign src_port = src_port_q;
  assign dst_port = dst_port_q;
`else
  assign src_port = P_SRC_PORT;
  assign dst_port = P_DST_PORT;
`endif

  assign out_free = !m_valid_q || m_axis_ip_ready;
  assign udp_len  = len_q + 16'd8;
  assign len_bad  = (s_axis_app_user == 16'd0) || (s_axis_app_user > P_MAX_PAYLOAD);

  assign s_axis_app_ready = ((state_q == S_PAY) && out_free) || (state_q == S_DROP);
  assign pay_acc          = (state_q == S_PAY) && out_free && s_axis_app_valid;
  assign drop_acc         = (state_q == S_DROP) && s_axis_app_valid;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ip_id_d   = ip_id_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    // A consumed beat empties the output register unless something reloads it below.
    m_valid_d = out_free ? 1'b0 : m_valid_q;
    len_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_axis_app_valid) begin
          len_d = s_axis_app_user;
          if (len_bad) begin
            len_err_d = 1'b1;
            state_d   = S_DROP;
          end else begin
            state_d = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (out_free) begin
          m_data_d  = {src_port, dst_port, udp_len, 16'h0000};
          m_user_d  = {udp_len, 3'b010, 8'd17, 13'd0, ip_id_q};
          m_keep_d  = 8'hFF;
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          state_d   = S_PAY;
        end
      end

      S_PAY: begin
        if (pay_acc) begin
          m_data_d  = s_axis_app_data;
          m_keep_d  = s_axis_app_keep;
          m_last_d  = s_axis_app_last;
          m_valid_d = 1'b1;
          if (s_axis_app_last) begin
            ip_id_d = ip_id_q + 16'd1;
            state_d = S_IDLE;
          end
        end
      end

      S_DROP: begin
        if (drop_acc && s_axis_app_last) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      ip_id_q   <= P_ID_INIT;
      m_data_q  <= 64'd0;
      m_user_q  <= 56'd0;
      m_keep_q  <= 8'd0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ip_id_q   <= ip_id_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      len_err_q <= len_err_d;
    end
  end

  assign m_axis_ip_data  = m_data_q;
  assign m_axis_ip_user  = m_user_q;
  assign m_axis_ip_keep  = m_keep_q;
  assign m_axis_ip_last  = m_last_q;
  assign m_axis_ip_valid = m_valid_q;
  assign o_len_err       = len_err_q;

endmodule
